// File: rtl/read_steer_router_if.sv
// Read-steer router bus interface.
//
// Groups the run control, the read-word input and the per-lane output handshakes
// of read_steer_router. The clock and reset stay plain module ports.
//   master : environment side (drives start, in_valid, in_data, lane_ready)
//   slave  : router side (drives hold, selectline, lane_*, word_count, overflow, done)
// Optional macro READ_STEER_ROUTER_PARITY_EN adds lane_parity[NLANES].
interface read_steer_router_if #(
  parameter int unsigned DW     = 8,
  parameter int unsigned NLANES = 8,
  parameter int unsigned NWORDS = 2048
);
  localparam int unsigned SelW = $clog2(NLANES);
  localparam int unsigned WcW  = $clog2(NWORDS + 1);

  logic                   start;
  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic                   hold;
  logic [SelW-1:0]        selectline;
  logic [NLANES*DW-1:0]   lane_data;
  logic [NLANES-1:0]      lane_valid;
  logic [NLANES-1:0]      lane_ready;
  logic [WcW-1:0]         word_count;
  logic                   overflow;
  logic                   done;
`ifdef READ_STEER_ROUTER_PARITY_EN
  logic [NLANES-1:0]      lane_parity;
`endif

  modport master (
    output start, in_valid, in_data, lane_ready,
`ifdef READ_STEER_ROUTER_PARITY_EN
    input  lane_parity,
`endif
    input  hold, selectline, lane_data, lane_valid, word_count, overflow, done
  );

  modport slave (
    input  start, in_valid, in_data, lane_ready,
`ifdef READ_STEER_ROUTER_PARITY_EN
    output lane_parity,
`endif
    output hold, selectline, lane_data, lane_valid, word_count, overflow, done
  );
endinterface

// File: rtl/read_steer_router.sv
// Read-steer router: distributes the RAM port-B read word stream round-robin across
// NLANES output lanes, each backed by a LANE_DEPTH-entry FIFO with valid/ready.
//
// Ports:
//   readclk : single clock, rising edge
//   reset   : synchronous, active-high
//   bus     : read_steer_router_if.slave
//             in  start, in_valid, in_data, lane_ready
//             out hold, selectline, lane_data (lane k at [k*DW +: DW]), lane_valid,
//                 word_count, overflow (sticky drop flag), done
// Optional macro READ_STEER_ROUTER_PARITY_EN: each FIFO entry also stores the even
// parity bit of the pushed word, presented on lane_parity (0 for an empty lane).
module read_steer_router #(
  parameter int unsigned DW         = 8,
  parameter int unsigned NLANES     = 8,
  parameter int unsigned LANE_DEPTH = 4,
  parameter int unsigned NWORDS     = 2048
) (
  input logic                readclk,
  input logic                reset,
  read_steer_router_if.slave bus
);
  localparam int unsigned SelW = $clog2(NLANES);
  localparam int unsigned PtrW = $clog2(LANE_DEPTH);
  localparam int unsigned CntW = $clog2(LANE_DEPTH + 1);
  localparam int unsigned WcW  = $clog2(NWORDS + 1);
`ifdef READ_STEER_ROUTER_PARITY_EN
  localparam int unsigned EW = DW + 1;
`else
  localparam int unsigned EW = DW;
`endif

  localparam logic [CntW-1:0] LaneFull = CntW'(LANE_DEPTH);
  localparam logic [WcW-1:0]  WcLast   = WcW'(NWORDS);

  typedef enum logic [1:0] {StIdle, StRoute, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [WcW-1:0]  wc_q, wc_d;
  logic            ovf_q, ovf_d;

  logic [EW-1:0]   mem_q    [NLANES][LANE_DEPTH];
  logic [EW-1:0]   mem_d    [NLANES][LANE_DEPTH];
  logic [PtrW-1:0] wr_ptr_q [NLANES];
  logic [PtrW-1:0] wr_ptr_d [NLANES];
  logic [PtrW-1:0] rd_ptr_q [NLANES];
  logic [PtrW-1:0] rd_ptr_d [NLANES];
  logic [CntW-1:0] cnt_q    [NLANES];
  logic [CntW-1:0] cnt_d    [NLANES];

  logic [NLANES-1:0] lane_empty;
  logic [NLANES-1:0] lane_pop;
  logic [NLANES-1:0] lane_push;
  logic              all_empty;
  logic              hold;
  logic              accept;
  logic [EW-1:0]     push_word;

  // Hold looks only at registered occupancy: a pop from the selected lane this
  // cycle does not open room until the next cycle.
  assign hold      = (state_q != StRoute) || (cnt_q[sel_q] == LaneFull);
  assign accept    = bus.in_valid && !hold;
  assign lane_push = accept ? (NLANES'(1) << sel_q) : '0;
  assign all_empty = &lane_empty;

`ifdef READ_STEER_ROUTER_PARITY_EN
  assign push_word = {^bus.in_data, bus.in_data};
`else
  assign push_word = bus.in_data;
`endif

  always_comb begin
    lane_empty = '0;
    lane_pop   = '0;
    for (int unsigned k = 0; k < NLANES; k++) begin
      lane_empty[k] = (cnt_q[k] == '0);
      // Pop decision uses the pre-push count, so a push into an empty lane never
      // falls through in the same cycle.
      lane_pop[k]   = !lane_empty[k] && bus.lane_ready[k];
    end
  end

  // Lane FIFO next state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int unsigned k = 0; k < NLANES; k++) begin
      if (lane_push[k]) begin
        mem_d[k][wr_ptr_q[k]] = push_word;
        wr_ptr_d[k]           = wr_ptr_q[k] + PtrW'(1);
      end
      if (lane_pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PtrW'(1);
      end
      case ({lane_push[k], lane_pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CntW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CntW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  // Run control FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wc_d    = wc_q;
    // Any word presented while hold is high (including outside ROUTE) is dropped.
    ovf_d   = ovf_q | (bus.in_valid & hold);
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          wc_d    = '0;
          ovf_d   = 1'b0;
          sel_d   = '0;
          state_d = StRoute;
        end
      end
      StRoute: begin
        if (accept) begin
          sel_d = sel_q + SelW'(1);
          if (wc_q != WcLast) begin
            wc_d = wc_q + WcW'(1);
          end
          if ((wc_q + WcW'(1)) == WcLast) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (all_empty) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!bus.start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge readclk) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned k = 0; k < NLANES; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wc_q     <= wc_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked by lane occupancy.
  always_ff @(posedge readclk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.lane_data = '0;
`ifdef READ_STEER_ROUTER_PARITY_EN
    bus.lane_parity = '0;
`endif
    for (int unsigned k = 0; k < NLANES; k++) begin
      if (!lane_empty[k]) begin
        bus.lane_data[k*DW +: DW] = mem_q[k][rd_ptr_q[k]][DW-1:0];
`ifdef READ_STEER_ROUTER_PARITY_EN
        bus.lane_parity[k] = mem_q[k][rd_ptr_q[k]][DW];
`endif
      end
    end
  end

  assign bus.hold       = hold;
  assign bus.selectline = sel_q;
  assign bus.lane_valid = ~lane_empty;
  assign bus.word_count = wc_q;
  assign bus.overflow   = ovf_q;
  assign bus.done       = (state_q == StDone);
endmodule

// File: tb/tb_read_steer_router.sv
// Self-checking bench for read_steer_router with a queue-based lane model.
module tb_read_steer_router;
  localparam int unsigned DW         = 8;
  localparam int unsigned NLANES     = 8;
  localparam int unsigned LANE_DEPTH = 4;
  localparam int unsigned NWORDS     = 40;
  localparam int unsigned SelW       = $clog2(NLANES);
  localparam int unsigned WcW        = $clog2(NWORDS + 1);

  logic readclk = 1'b0;
  logic reset;
  always #5 readclk = ~readclk;

  read_steer_router_if #(.DW(DW), .NLANES(NLANES), .NWORDS(NWORDS)) bus ();

  read_steer_router #(
    .DW(DW), .NLANES(NLANES), .LANE_DEPTH(LANE_DEPTH), .NWORDS(NWORDS)
  ) dut (
    .readclk(readclk),
    .reset  (reset),
    .bus    (bus)
  );

  // Reference model: phase 0 idle, 1 route, 2 drain, 3 done.
  logic [DW-1:0] mq [NLANES][$];
  int m_phase, m_sel, m_wc;
  bit m_ovf;
  int checks = 0;
  int errors = 0;

  function automatic bit m_hold();
    return (m_phase != 1) || (mq[m_sel].size() == LANE_DEPTH);
  endfunction

  function automatic logic [NLANES-1:0] m_valid();
    logic [NLANES-1:0] v = '0;
    for (int k = 0; k < NLANES; k++) v[k] = (mq[k].size() > 0);
    return v;
  endfunction

  function automatic logic [NLANES*DW-1:0] m_data();
    logic [NLANES*DW-1:0] v = '0;
    for (int k = 0; k < NLANES; k++) if (mq[k].size() > 0) v[k*DW +: DW] = mq[k][0];
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NLANES; k++) mq[k].delete();
    m_phase = 0; m_sel = 0; m_wc = 0; m_ovf = 0;
  endfunction

  function automatic void model_step();
    bit h = m_hold();
    bit acc = bus.in_valid && !h;
    bit empty_all = 1;
    bit [NLANES-1:0] pop = '0;
    for (int k = 0; k < NLANES; k++) begin
      pop[k] = (mq[k].size() > 0) && bus.lane_ready[k];
      if (mq[k].size() > 0) empty_all = 0;
    end
    if (bus.in_valid && h) m_ovf = 1;
    case (m_phase)
      0: if (bus.start) begin m_wc = 0; m_ovf = 0; m_sel = 0; m_phase = 1; end
      1: if (acc) begin
        mq[m_sel].push_back(bus.in_data);
        m_sel = (m_sel + 1) % NLANES;
        m_wc++;
        if (m_wc == NWORDS) m_phase = 2;
      end
      2: if (empty_all) m_phase = 3;
      default: if (!bus.start) m_phase = 0;
    endcase
    for (int k = 0; k < NLANES; k++) if (pop[k]) void'(mq[k].pop_front());
  endfunction

  task automatic tick();
    if (reset) model_reset(); else model_step();
    @(posedge readclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.lane_ready = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.hold !== 1'b1 || bus.selectline !== '0 || bus.word_count !== '0 ||
        bus.overflow !== 1'b0 || bus.done !== 1'b0 || bus.lane_valid !== '0 ||
        bus.lane_data !== '0) begin
      errors++;
      $display("FAIL reset: hold=%b sel=%0d wc=%0d ovf=%b done=%b lv=%h ld=%h, want 1 0 0 0 0 0 0",
               bus.hold, bus.selectline, bus.word_count, bus.overflow, bus.done,
               bus.lane_valid, bus.lane_data);
    end
  endtask

  // Full run; full_rate streams index data with every lane ready.
  task automatic test_stream(input bit full_rate);
    int idx = 0;
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int cyc = 0; cyc < 2000 && m_phase != 3; cyc++) begin
      if (full_rate) begin
        bus.in_valid = (m_phase == 1); bus.in_data = DW'(idx); bus.lane_ready = '1;
        if (m_phase == 1) idx++;
      end else begin
        bus.in_valid = ($urandom_range(0, 3) != 0); bus.in_data = DW'($urandom);
        bus.lane_ready = NLANES'($urandom);
      end
      checks++;
      if (bus.hold !== m_hold() || bus.selectline !== SelW'(m_sel) ||
          bus.word_count !== WcW'(m_wc) || bus.overflow !== m_ovf ||
          bus.done !== (m_phase == 3) || bus.lane_valid !== m_valid() ||
          bus.lane_data !== m_data()) begin
        errors++;
        $display("FAIL stream%0d cyc %0d: hold=%b sel=%0d wc=%0d ovf=%b lv=%h ld=%h, want %b %0d %0d %b %h %h",
                 full_rate, cyc, bus.hold, bus.selectline, bus.word_count, bus.overflow,
                 bus.lane_valid, bus.lane_data, m_hold(), m_sel, m_wc, m_ovf, m_valid(), m_data());
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.word_count !== WcW'(NWORDS) || m_phase != 3) begin
      errors++;
      $display("FAIL stream%0d end: done=%b wc=%0d, want 1 %0d", full_rate, bus.done,
               bus.word_count, NWORDS);
    end
    if (full_rate) begin
      checks++;
      if (bus.overflow !== 1'b0) begin
        errors++;
        $display("FAIL stream overflow: got %b want 0", bus.overflow);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.hold !== 1'b1) begin
      errors++;
      $display("FAIL stream idle: done=%b hold=%b want 0 1", bus.done, bus.hold);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.lane_ready = '0; bus.in_valid = 1'b1;
    for (int i = 0; i < 32 + 3; i++) begin
      bus.in_data = DW'($urandom);
      checks++;
      if (bus.hold !== m_hold() || bus.selectline !== SelW'(m_sel) ||
          bus.word_count !== WcW'(m_wc) || bus.lane_data !== m_data()) begin
        errors++;
        $display("FAIL fill %0d: hold=%b sel=%0d wc=%0d ld=%h, want %b %0d %0d %h", i, bus.hold,
                 bus.selectline, bus.word_count, bus.lane_data, m_hold(), m_sel, m_wc, m_data());
      end
      tick();
      if (i == 31) begin
        checks++;
        if (bus.hold !== 1'b1 || bus.selectline !== '0 || bus.word_count !== WcW'(32) ||
            bus.lane_valid !== '1) begin
          errors++;
          $display("FAIL full: hold=%b sel=%0d wc=%0d lv=%h, want 1 0 32 ff", bus.hold,
                   bus.selectline, bus.word_count, bus.lane_valid);
        end
      end
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.word_count !== WcW'(32) || bus.selectline !== '0) begin
      errors++;
      $display("FAIL drop: ovf=%b wc=%0d sel=%0d, want 1 32 0", bus.overflow, bus.word_count,
               bus.selectline);
    end
    // Pop lane 0: hold must stay high during the popping cycle.
    bus.lane_ready = NLANES'(1);
    checks++;
    if (bus.hold !== 1'b1) begin
      errors++;
      $display("FAIL hold during pop: got %b want 1", bus.hold);
    end
    tick();
    bus.lane_ready = '0; bus.in_data = 8'hA5;
    checks++;
    if (bus.hold !== 1'b0) begin
      errors++;
      $display("FAIL hold release: got %b want 0", bus.hold);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.word_count !== WcW'(33) || bus.selectline !== SelW'(1) ||
        bus.lane_data !== m_data() || mq[0].size() != 4 || mq[0][3] != 8'hA5) begin
      errors++;
      $display("FAIL word 33: wc=%0d sel=%0d ld=%h, want 33 1 %h", bus.word_count,
               bus.selectline, bus.lane_data, m_data());
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.lane_ready = '0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin bus.in_data = DW'(i + 1); tick(); end
    bus.in_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (bus.lane_valid !== '0 || bus.word_count !== '0 || bus.selectline !== '0 ||
        bus.hold !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: lv=%h wc=%0d sel=%0d hold=%b done=%b, want 0 0 0 1 0",
               bus.lane_valid, bus.word_count, bus.selectline, bus.hold, bus.done);
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h3C; tick(); bus.in_valid = 1'b0;
    checks++;
    if (bus.lane_valid !== NLANES'(1) || bus.lane_data[DW-1:0] !== 8'h3C) begin
      errors++;
      $display("FAIL restart: lv=%h lane0=%h, want 01 3c", bus.lane_valid, bus.lane_data[DW-1:0]);
    end
  endtask

  task automatic test_done_hold();
    do_reset();
    bus.start = 1'b1; bus.lane_ready = '1;
    for (int cyc = 0; cyc < 500 && m_phase != 3; cyc++) begin
      bus.in_valid = (m_phase == 1); bus.in_data = DW'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i == 3);
      checks++;
      if (bus.done !== 1'b1 || bus.hold !== 1'b1) begin
        errors++;
        $display("FAIL done hold %0d: done=%b hold=%b, want 1 1", i, bus.done, bus.hold);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done drop: ovf=%b done=%b, want 1 1", bus.overflow, bus.done);
    end
    bus.start = 1'b0; tick();
    checks++;
    if (bus.done !== 1'b0 || bus.hold !== 1'b1) begin
      errors++;
      $display("FAIL done exit: done=%b hold=%b, want 0 1", bus.done, bus.hold);
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0 || bus.hold !== 1'b0 || bus.word_count !== '0) begin
      errors++;
      $display("FAIL new run: ovf=%b hold=%b wc=%0d, want 0 0 0", bus.overflow, bus.hold,
               bus.word_count);
    end
  endtask

`ifdef READ_STEER_ROUTER_PARITY_EN
  task automatic test_parity();
    do_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.lane_ready = '0; bus.in_valid = 1'b1;
    bus.in_data = 8'h07; tick();
    bus.in_data = 8'h03; tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.lane_parity !== 8'b0000_0001) begin
      errors++;
      $display("FAIL parity: got %b want 00000001", bus.lane_parity);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_stream(1'b1);
    test_stream(1'b0);
    test_backpressure();
    test_reset_mid_run();
    test_done_hold();
`ifdef READ_STEER_ROUTER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got hung want done");
    $fatal(1);
  end
endmodule
